// File: rtl/route_demux.sv
// -----------------------------------------------------------------------------
// route_demux
//
// One-to-many AXI-Stream packet demultiplexer for the mesh router. The first
// beat of every packet is a routing header. Its target coordinates are compared
// against this router's own position using X-first (XY) routing to choose an
// output port. The header and the payload beats that follow it (the count is
// carried in the header) are forwarded to that port. The route is held until
// the count is exhausted.
//
// Header layout (XW = MAX_ROUTERS_X_WIDTH, YW = MAX_ROUTERS_Y_WIDTH):
//   [YW-1:0]                target_y
//   [XW+YW-1:YW]            target_x
//   [2(XW+YW)-1:XW+YW]      source coordinates (ignored)
//   [2(XW+YW)+7:2(XW+YW)]   payload beat count N (beats after the header)
//
// Output port indices: 0 local, 1 north, 2 east, 3 south, 4 west.
//
// The AXI-Stream input "in" and the per-port outputs "out[k]" are carried as
// flattened in_* signals and packed out_* vectors. Index k of every out_*
// vector is output port k.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   in_tvalid/tready  input stream handshake
//   in_tdata/tid/tlast input stream payload and sideband
//   out_tvalid[k]     valid for output port k (only the routed port is raised)
//   out_tready[k]     ready from output port k
//   out_tdata/tid/tlast[k] payload and sideband broadcast to every port
//   current_port      port locked for the current packet
//   busy              high while payload beats of a packet are outstanding
//   hdr_err           one-cycle pulse after a non-header beat is dropped in IDLE
//
// Build option ROUTE_DEMUX_OUT_REG_EN: when this macro is defined, a 2-entry
// skid buffer (beat plus port tag) is inserted in front of the outputs. This
// adds one cycle of latency, keeps full throughput, and removes the
// combinational path from out_tready to in_tready. When the macro is not
// defined, the input-to-output path is purely combinational.
// -----------------------------------------------------------------------------
module route_demux #(
    parameter int DATA_WIDTH           = 32,
    parameter int ID_WIDTH             = 4,
    parameter int CHANNEL_NUMBER       = 5,
    parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
    parameter int MAX_ROUTERS_X        = 4,
    parameter int MAX_ROUTERS_X_WIDTH  = $clog2(MAX_ROUTERS_X),
    parameter int MAX_ROUTERS_Y        = 4,
    parameter int MAX_ROUTERS_Y_WIDTH  = $clog2(MAX_ROUTERS_Y),
    parameter int ROUTER_X             = 0,
    parameter int ROUTER_Y             = 0,
    parameter logic [ID_WIDTH-1:0] ROUTING_HEADER = '1
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    // packet input stream
    input  logic                                           in_tvalid,
    output logic                                           in_tready,
    input  logic [DATA_WIDTH-1:0]                          in_tdata,
    input  logic [ID_WIDTH-1:0]                            in_tid,
    input  logic                                           in_tlast,
    // per-port output streams
    output logic [CHANNEL_NUMBER-1:0]                      out_tvalid,
    input  logic [CHANNEL_NUMBER-1:0]                      out_tready,
    output logic [CHANNEL_NUMBER-1:0][DATA_WIDTH-1:0]      out_tdata,
    output logic [CHANNEL_NUMBER-1:0][ID_WIDTH-1:0]        out_tid,
    output logic [CHANNEL_NUMBER-1:0]                      out_tlast,
    // status
    output logic [CHANNEL_NUMBER_WIDTH-1:0]                current_port,
    output logic                                           busy,
    output logic                                           hdr_err
);

    localparam int XW = MAX_ROUTERS_X_WIDTH;
    localparam int YW = MAX_ROUTERS_Y_WIDTH;
    localparam int HW = XW + YW;
    localparam int CW = CHANNEL_NUMBER_WIDTH;

    typedef logic [CW-1:0] port_t;

    localparam port_t PORT_LOCAL = port_t'(0);
    localparam port_t PORT_NORTH = port_t'(1);
    localparam port_t PORT_EAST  = port_t'(2);
    localparam port_t PORT_SOUTH = port_t'(3);
    localparam port_t PORT_WEST  = port_t'(4);

    localparam logic [XW-1:0] ROUTER_X_L = XW'(ROUTER_X);
    localparam logic [YW-1:0] ROUTER_Y_L = YW'(ROUTER_Y);

    typedef enum logic {
        IDLE,
        FWD
    } state_t;

    state_t          state;
    logic [7:0]      beat_count;

    logic [XW-1:0]   target_x;
    logic [YW-1:0]   target_y;
    logic [7:0]      hdr_count;
    logic            is_hdr;
    port_t           route_port;
    port_t           sel_port;
    logic            fwd_en;
    logic            in_hs;

    // ------------------------------------------------------------------
    // Header decode and XY route selection
    // ------------------------------------------------------------------
    assign target_y  = in_tdata[YW-1:0];
    assign target_x  = in_tdata[HW-1:YW];
    assign hdr_count = in_tdata[2*HW+7:2*HW];
    assign is_hdr    = (in_tid == ROUTING_HEADER);

    // Out-of-mesh targets fall through the same comparisons on purpose.
    always_comb begin
        route_port = PORT_LOCAL;
        if (target_x > ROUTER_X_L) begin
            route_port = PORT_EAST;
        end else if (target_x < ROUTER_X_L) begin
            route_port = PORT_WEST;
        end else if (target_y > ROUTER_Y_L) begin
            route_port = PORT_NORTH;
        end else if (target_y < ROUTER_Y_L) begin
            route_port = PORT_SOUTH;
        end
    end

    // In FWD the locked port wins, and the count rather than TID decides
    // which beats belong to the packet. In IDLE only a header is forwarded.
    assign sel_port = (state == FWD) ? current_port : route_port;
    assign fwd_en   = (state == FWD) || is_hdr;
    assign in_hs    = in_tvalid && in_tready;

    // ------------------------------------------------------------------
    // Packet FSM (state, counter, locked port, status outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            beat_count   <= '0;
            current_port <= '0;
            busy         <= 1'b0;
            hdr_err      <= 1'b0;
        end else begin
            hdr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_hs) begin
                        if (is_hdr) begin
                            current_port <= route_port;
                            beat_count   <= hdr_count;
                            if (hdr_count != '0) begin
                                state <= FWD;
                                busy  <= 1'b1;
                            end
                        end else begin
                            hdr_err <= 1'b1;
                        end
                    end
                end
                FWD: begin
                    if (in_hs) begin
                        if (beat_count == 8'd1) begin
                            beat_count <= '0;
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end else begin
                            beat_count <= beat_count - 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef ROUTE_DEMUX_OUT_REG_EN
    // ------------------------------------------------------------------
    // Combinational pass-through output stage
    // ------------------------------------------------------------------
    logic sel_ready;

    always_comb begin
        sel_ready = 1'b0;
        for (int unsigned k = 0; k < CHANNEL_NUMBER; k++) begin
            if (sel_port == port_t'(k)) begin
                sel_ready = out_tready[k];
            end
        end
    end

    // A dropped (non-header) beat in IDLE is always accepted. Nothing is
    // offered downstream while reset is held.
    assign in_tready = rst_n && (fwd_en ? sel_ready : 1'b1);

    always_comb begin
        out_tvalid = '0;
        out_tdata  = '0;
        out_tid    = '0;
        out_tlast  = '0;
        for (int unsigned k = 0; k < CHANNEL_NUMBER; k++) begin
            out_tvalid[k] = rst_n && in_tvalid && fwd_en && (sel_port == port_t'(k));
            out_tdata[k]  = in_tdata;
            out_tid[k]    = in_tid;
            out_tlast[k]  = in_tlast;
        end
    end
`else
    // ------------------------------------------------------------------
    // Registered output stage: 2-entry skid buffer of beat + port tag.
    // The route, counter and hdr_err are all resolved at the input handshake.
    // The buffer only replays accepted beats to their tagged port.
    // ------------------------------------------------------------------
    logic [1:0][DATA_WIDTH-1:0] buf_tdata;
    logic [1:0][ID_WIDTH-1:0]   buf_tid;
    logic [1:0]                 buf_tlast;
    logic [1:0][CW-1:0]         buf_port;
    logic                       wr_ptr;
    logic                       rd_ptr;
    logic [1:0]                 buf_count;
    logic                       push;
    logic                       pop;
    logic                       head_valid;
    port_t                      head_port;
    logic                       head_ready;

    assign head_valid = (buf_count != 2'd0);
    assign head_port  = buf_port[rd_ptr];
    assign push       = in_hs && fwd_en;
    assign pop        = head_valid && head_ready;
    assign in_tready  = rst_n && (buf_count != 2'd2);

    always_comb begin
        head_ready = 1'b0;
        for (int unsigned k = 0; k < CHANNEL_NUMBER; k++) begin
            if (head_port == port_t'(k)) begin
                head_ready = out_tready[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_tdata <= '0;
            buf_tid   <= '0;
            buf_tlast <= '0;
            buf_port  <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            buf_count <= 2'd0;
        end else begin
            if (push) begin
                buf_tdata[wr_ptr] <= in_tdata;
                buf_tid[wr_ptr]   <= in_tid;
                buf_tlast[wr_ptr] <= in_tlast;
                buf_port[wr_ptr]  <= sel_port;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            buf_count <= buf_count + 2'(push) - 2'(pop);
        end
    end

    always_comb begin
        out_tvalid = '0;
        out_tdata  = '0;
        out_tid    = '0;
        out_tlast  = '0;
        for (int unsigned k = 0; k < CHANNEL_NUMBER; k++) begin
            out_tvalid[k] = head_valid && (head_port == port_t'(k));
            out_tdata[k]  = buf_tdata[rd_ptr];
            out_tid[k]    = buf_tid[rd_ptr];
            out_tlast[k]  = buf_tlast[rd_ptr];
        end
    end
`endif

endmodule

// File: doc/route_demux.md
# route_demux

One-to-many AXI-Stream packet demultiplexer for the router, mirroring the input arbiter. It accepts one packet stream whose first beat is a routing header and computes the output port by XY routing against the router's own coordinates. It forwards the header plus all payload beats to that port and holds the route until the beat count from the header is exhausted.

## Interface
- DATA_WIDTH, 32, TDATA width
- ID_WIDTH, 4, TID width (TID present; header beat marked TID == ROUTING_HEADER)
- CHANNEL_NUMBER, 5, output ports: 0 local, 1 north, 2 east, 3 south, 4 west
- CHANNEL_NUMBER_WIDTH, $clog2(CHANNEL_NUMBER), port index width
- MAX_ROUTERS_X, 4, mesh columns; MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X)
- MAX_ROUTERS_Y, 4, mesh rows; MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y)
- ROUTER_X, 0, this router's column
- ROUTER_Y, 0, this router's row
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- in  axis_if.s  1 interface  packet input stream
- out  axis_if.m  CHANNEL_NUMBER interfaces  per-port output streams
- current_port  output  CHANNEL_NUMBER_WIDTH  port locked for current packet
- busy  output  1  high while a packet is in flight (after header, before last beat)
- hdr_err  output  1  one-cycle pulse when a non-header beat is dropped in IDLE

## Operation
- Header fields, with XW = MAX_ROUTERS_X_WIDTH and YW = MAX_ROUTERS_Y_WIDTH: target_y = TDATA[YW-1:0]; target_x = TDATA[XW+YW-1:YW]; source coordinates in TDATA[2(XW+YW)-1:XW+YW], which are ignored; beat count N = TDATA[2(XW+YW)+7:2(XW+YW)], 8 bits, counting payload beats after the header.
- Route selection, X first:
  - target_x > ROUTER_X: east (2).
  - target_x < ROUTER_X: west (4).
  - Otherwise target_y > ROUTER_Y: north (1).
  - Otherwise target_y < ROUTER_Y: south (3).
  - Otherwise local (0).
- FSM, IDLE:
  - in.TVALID with TID == ROUTING_HEADER: route computed combinationally and header forwarded the same cycle to the selected port.
  - On the header handshake: current_port latched, counter loaded with N.
  - If N != 0, go to FWD; if N == 0, stay IDLE (single-beat packet).
- FSM, FWD:
  - Every beat goes to current_port regardless of TID; the counter is authoritative.
  - Counter decrements on each handshake.
  - A handshake with counter == 1 returns the FSM to IDLE.
- Bad header (IDLE, TVALID, TID != ROUTING_HEADER): beat is accepted with in.TREADY=1 and not forwarded; hdr_err pulses the next cycle.
- Output gating:
  - TDATA, TID and remaining sideband are broadcast from the input to all ports.
  - Only the selected port sees TVALID; all other out[k].TVALID = 0.
  - in.TREADY = out[sel].TREADY, where sel is the routed port in IDLE and current_port in FWD.
- busy = (state == FWD).
- Counter is 8 bits and does not wrap: it never decrements below 1 in FWD, and reloads only on a header in IDLE.

## Timing
- Reset values: state IDLE, counter 0, current_port 0, busy 0, hdr_err 0, all out[k].TVALID 0, in.TREADY 0 while rst_n low.
- Base build latency: 0 cycles, fully combinational in-to-out path; one beat per cycle sustained.
- AXI-S rules on outputs:
  - TVALID is never withdrawn without a handshake while in.TVALID stays high.
  - Data is stable under backpressure, because it is passed through from in.
- Route changes only at packet boundaries.
- The IDLE→FWD transition and counter load take effect on the clock edge of the header handshake.
- A header arriving in the cycle right after the last beat is accepted back-to-back; no bubble is required.
- Reset asserted mid-packet: FSM returns to IDLE immediately and the partial packet is abandoned. The first post-reset beat must be a header; otherwise it is dropped with hdr_err.
- A target outside the mesh (target_x ≥ MAX_ROUTERS_X) is routed per the same compare rule; no special case.

## Configuration
- ROUTE_DEMUX_OUT_REG_EN defined:
  - A 2-entry skid buffer (beat plus port tag) sits between the routing stage and the outputs.
  - Latency is 1 cycle; full throughput is kept.
  - in.TREADY is driven from buffer-not-full, so there is no combinational TREADY path from any out[k].
  - Reset clears both entries.
  - Route, counter and hdr_err timing are referenced to the input handshake.
- Undefined: the combinational pass-through described above.

## Test plan
- ROUTER_X=1, ROUTER_Y=1, XW=YW=2. Header TDATA=0x030D (x=3, y=1, N=3), then 3 payload beats, no stall → all 4 beats on out[2] in 4 cycles; current_port=2; busy high for 3 cycles; other TVALIDs 0.
- Header x=1, y=1, N=0 → single beat on out[0]; busy stays 0; next header accepted the following cycle.
- Header x=1, y=0, N=2 with out[3].TREADY low for 3 cycles after the header → in.TREADY low for those cycles; beats arrive in order on out[3] with stable data; counter ends at IDLE.
- Headers to x=0 (west) then y=3 (north), back-to-back, N=1 each → 2 beats on out[4], then 2 beats on out[1], no bubble.
- In IDLE, a beat with TID != ROUTING_HEADER → accepted, no out TVALID, hdr_err high for exactly 1 cycle.
- Reset asserted after beat 2 of an N=5 packet → busy 0, all TVALID 0; next header routes correctly. Repeat this test with ROUTE_DEMUX_OUT_REG_EN defined, checking 1-cycle latency.
